// File: rtl/if_id_buffer.sv
// Two-entry in-order skid buffer between instruction fetch and decode.
// Registered outputs only: fetch ready never depends on decode ready.
module if_id_buffer #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter logic [31:0] RESET_PC  = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_instruction,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    input  logic        flush,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_misaligned,
    output logic [1:0]  count,
    output logic [7:0]  flush_drops
);

    logic [31:0] slotInstr_q [2];
    logic [31:0] slotPc_q    [2];
    logic        rdPtr_q, rdPtr_d;
    logic        wrPtr_q, wrPtr_d;
    logic [1:0]  count_q, count_d;
    logic [7:0]  flushDrops_q, flushDrops_d;
    logic        push, pop;
    logic [8:0]  dropSum;

    assign if_ready = (count_q != 2'd2);
    assign id_valid = (count_q != 2'd0);
    assign push     = if_valid && if_ready && !flush;
    assign pop      = id_valid && id_ready && !flush;

    assign id_instruction = id_valid ? slotInstr_q[rdPtr_q] : NOP_INSTR;
    assign id_pc          = id_valid ? slotPc_q[rdPtr_q]    : RESET_PC;
    assign id_pc_plus4    = id_pc + 32'd4;
    assign id_misaligned  = id_valid && (id_pc[1:0] != 2'b00);
    assign count          = count_q;
    assign flush_drops    = flushDrops_q;

    assign dropSum = {1'b0, flushDrops_q} + {7'd0, count_q};

    always_comb begin
        rdPtr_d      = rdPtr_q;
        wrPtr_d      = wrPtr_q;
        count_d      = count_q;
        flushDrops_d = flushDrops_q;
        if (flush) begin
            rdPtr_d      = 1'b0;
            wrPtr_d      = 1'b0;
            count_d      = 2'd0;
            flushDrops_d = dropSum[8] ? 8'hFF : dropSum[7:0];
        end else begin
            if (push) wrPtr_d = ~wrPtr_q;
            if (pop)  rdPtr_d = ~rdPtr_q;
            if (push && !pop)      count_d = count_q + 2'd1;
            else if (pop && !push) count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr_q      <= 1'b0;
            wrPtr_q      <= 1'b0;
            count_q      <= 2'd0;
            flushDrops_q <= 8'd0;
        end else begin
            rdPtr_q      <= rdPtr_d;
            wrPtr_q      <= wrPtr_d;
            count_q      <= count_d;
            flushDrops_q <= flushDrops_d;
        end
    end

    // Slot storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            slotInstr_q[wrPtr_q] <= if_instruction;
            slotPc_q[wrPtr_q]    <= if_pc;
        end
    end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h00000013, the instruction presented on id_instruction when the buffer is empty.
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000, the value presented on id_pc when the buffer is empty.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_valid  input  1  fetch stage offers an instruction this cycle.
REQ-006 SHALL have port if_instruction  input  32  instruction word from fetch.
REQ-007 SHALL have port if_pc  input  32  PC of if_instruction.
REQ-008 SHALL have port if_ready  output  1  buffer accepts an offer this cycle.
REQ-009 SHALL have port flush  input  1  discard all buffered entries (taken branch/jump).
REQ-010 SHALL have port id_ready  input  1  decode stage consumes the head entry this cycle.
REQ-011 SHALL have port id_valid  output  1  head entry is valid.
REQ-012 SHALL have port id_instruction  output  32  head instruction.
REQ-013 SHALL have port id_pc  output  32  head PC.
REQ-014 SHALL have port id_pc_plus4  output  32  id_pc + 4.
REQ-015 SHALL have port id_misaligned  output  1  head PC not word aligned.
REQ-016 SHALL have port count  output  2  entries held (0..2).
REQ-017 SHALL have port flush_drops  output  8  number of valid entries discarded by flush, saturating.

Function
REQ-018 SHALL be a 2-entry in-order FIFO of {instruction, pc} using a 1-bit read pointer, a 1-bit write pointer and a 2-bit count.
REQ-019 SHALL drive if_ready = (count != 2), a function of registered state only, with no combinational path from id_ready.
REQ-020 SHALL push when if_valid && if_ready && !flush, writing the slot at the write pointer and toggling the write pointer.
REQ-021 SHALL pop when id_valid && id_ready && !flush, toggling the read pointer.
REQ-022 SHALL drive id_valid = (count != 0).
REQ-023 SHALL present the head slot on id_instruction/id_pc when count != 0, and NOP_INSTR/RESET_PC when count == 0.
REQ-024 SHALL provide no input-to-output bypass: an entry pushed at edge N is first visible on id_* after edge N (1-cycle latency).
REQ-025 SHALL update count as +1 on push only, -1 on pop only, and unchanged on push+pop (possible only when count == 1).
REQ-026 SHALL, when count == 2, ignore if_valid (no push), and a pop that cycle SHALL leave count == 1 with if_ready asserted the following cycle.
REQ-027 SHALL, when count == 0, pop SHALL NOT occur regardless of id_ready.
REQ-028 SHALL, on flush, set count to 0 and both pointers to 0 at the next edge, overriding any push or pop that cycle; the if_* offer of that cycle is dropped.
REQ-029 SHALL, on flush, add the pre-flush count to flush_drops, saturating at 255.
REQ-030 SHALL compute id_pc_plus4 as id_pc + 32'd4 modulo 2^32 (32'hFFFFFFFC wraps to 0).
REQ-031 SHALL drive id_misaligned = id_valid && (id_pc[1:0] != 2'b00).
REQ-032 SHALL hold stored slot contents unchanged except on push to that slot.

Reset
REQ-033 SHALL, while rst is low, immediately force count=0, pointers=0 and flush_drops=0, giving if_ready=1, id_valid=0, id_instruction=NOP_INSTR, id_pc=RESET_PC, id_pc_plus4=RESET_PC+4 and id_misaligned=0.
REQ-034 SHALL, on assertion of rst mid-operation, discard all buffered entries without counting them in flush_drops.
REQ-035 SHALL NOT require slot storage to be reset.

Verification
REQ-036 SHALL cover streaming: push pc 0x0,0x4,0x8 with id_ready=1 every cycle -> id_pc 0x0,0x4,0x8 on consecutive cycles, 1-cycle latency, count stays 1.
REQ-037 SHALL cover backpressure: id_ready=0 and 3 offers -> count=2, if_ready=0, third offer held by fetch; one pop -> if_ready=1 the next cycle, order preserved.
REQ-038 SHALL cover flush: count=2, then flush with if_valid=1 and id_ready=1 -> count=0, id_instruction=0x00000013, flush_drops=2, offered entry lost.
REQ-039 SHALL cover boundary: push pc 0xFFFFFFFC -> id_pc_plus4=0x00000000; push pc 0x00000102 -> id_misaligned=1.
REQ-040 SHALL cover reset: assert rst low asynchronously with count=2 -> id_valid=0 before the next clock edge and flush_drops=0; 130 flushes of 2 entries each -> flush_drops=255.
